// File: rtl/pong_score_ctrl.sv
// Pong match sequencer and two-digit BCD scoreboard feeding the text renderer.
// Define SCORE_DEUCE_EN to require a two-point lead to win (win by two).
module pong_score_ctrl #(
  parameter int unsigned WIN_SCORE   = 11,
  parameter int unsigned SERVE_DELAY = 120
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       refr_tick_i,
  input  logic       start_i,
  input  logic       p1_point_i,
  input  logic       p2_point_i,
  output logic [3:0] dig3_o,
  output logic [3:0] dig2_o,
  output logic [3:0] dig1_o,
  output logic [3:0] dig0_o,
  output logic       serve_o,
  output logic       game_active_o,
  output logic       game_over_o,
  output logic [1:0] winner_o
);

  localparam int unsigned CNT_W = 10;
  localparam int unsigned BIN_W = 7;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [BIN_W-1:0] WIN_BIN  = BIN_W'(WIN_SCORE);
  localparam logic [BIN_W-1:0] BIN_MAX  = BIN_W'(99);
  localparam logic [7:0]       BCD_MAX  = 8'h99;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       p1_bcd_q, p2_bcd_q;
  logic [BIN_W-1:0] p1_bin_q, p2_bin_q;
  logic             serve_q, active_q, over_q;
  logic [1:0]       winner_q;

  logic [7:0]       p1_bcd_d, p2_bcd_d;
  logic [BIN_W-1:0] p1_bin_d, p2_bin_d;
  logic             p1_win_c, p2_win_c;

  // Saturating BCD increment: ones wrap 9->0 with carry, 99 holds.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v == BCD_MAX) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Candidate scores if the corresponding player scores this cycle.
  always_comb begin
    p1_bcd_d = bcd_inc(p1_bcd_q);
    p2_bcd_d = bcd_inc(p2_bcd_q);
    p1_bin_d = (p1_bin_q == BIN_MAX) ? p1_bin_q : p1_bin_q + BIN_W'(1);
    p2_bin_d = (p2_bin_q == BIN_MAX) ? p2_bin_q : p2_bin_q + BIN_W'(1);
  end

`ifdef SCORE_DEUCE_EN
  localparam logic [BIN_W:0] LEAD = (BIN_W+1)'(2);

  // Win needs the target plus a two-point lead; reaching 99 ends it regardless.
  assign p1_win_c = ((p1_bin_d >= WIN_BIN) &&
                     ({1'b0, p1_bin_d} >= ({1'b0, p2_bin_q} + LEAD))) ||
                    (p1_bin_d == BIN_MAX);
  assign p2_win_c = ((p2_bin_d >= WIN_BIN) &&
                     ({1'b0, p2_bin_d} >= ({1'b0, p1_bin_q} + LEAD))) ||
                    (p2_bin_d == BIN_MAX);
`else
  assign p1_win_c = (p1_bin_d == WIN_BIN);
  assign p2_win_c = (p2_bin_d == WIN_BIN);
`endif

  // Match sequencer; every output is a register updated here.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      p1_bcd_q <= '0;
      p2_bcd_q <= '0;
      p1_bin_q <= '0;
      p2_bin_q <= '0;
      serve_q  <= 1'b0;
      active_q <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= 2'b00;
    end else begin
      serve_q <= 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start_i) begin
            p1_bcd_q <= '0;
            p2_bcd_q <= '0;
            p1_bin_q <= '0;
            p2_bin_q <= '0;
            winner_q <= 2'b00;
            cnt_q    <= '0;
            over_q   <= 1'b0;
            active_q <= 1'b1;
            state_q  <= S_SERVE;
          end
        end
        S_SERVE: begin
          if (refr_tick_i) begin
            if (cnt_q == CNT_LAST) begin
              serve_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= S_PLAY;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_PLAY: begin
          // Simultaneous point pulses cancel out.
          if (p1_point_i != p2_point_i) begin
            if (p1_point_i) begin
              p1_bcd_q <= p1_bcd_d;
              p1_bin_q <= p1_bin_d;
            end else begin
              p2_bcd_q <= p2_bcd_d;
              p2_bin_q <= p2_bin_d;
            end
            if ((p1_point_i && p1_win_c) || (p2_point_i && p2_win_c)) begin
              winner_q <= p1_point_i ? 2'b01 : 2'b10;
              over_q   <= 1'b1;
              active_q <= 1'b0;
              state_q  <= S_OVER;
            end else begin
              cnt_q   <= '0;
              state_q <= S_SERVE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dig3_o        = p1_bcd_q[7:4];
  assign dig2_o        = p1_bcd_q[3:0];
  assign dig1_o        = p2_bcd_q[7:4];
  assign dig0_o        = p2_bcd_q[3:0];
  assign serve_o       = serve_q;
  assign game_active_o = active_q;
  assign game_over_o   = over_q;
  assign winner_o      = winner_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Self-checking bench for pong_score_ctrl against an integer-score match model.
module tb_pong_score_ctrl;

  localparam int WIN   = 11;
  localparam int DELAY = 120;

  localparam int PH_IDLE  = 0;
  localparam int PH_SERVE = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_OVER  = 3;

  logic       clk = 1'b0;
  logic       reset, refr_tick, start, p1_point, p2_point;
  logic [3:0] dig3, dig2, dig1, dig0;
  logic       serve, game_active, game_over;
  logic [1:0] winner;

  int n_vec = 0;
  int n_err = 0;

  int         m_phase = PH_IDLE;
  int         m_p1 = 0;
  int         m_p2 = 0;
  int         m_ticks = 0;
  bit         m_serve = 1'b0;
  logic [1:0] m_winner = 2'b00;

  always #5 clk = ~clk;

  pong_score_ctrl #(.WIN_SCORE(WIN), .SERVE_DELAY(DELAY)) dut (
    .clk_i(clk), .reset_i(reset), .refr_tick_i(refr_tick), .start_i(start),
    .p1_point_i(p1_point), .p2_point_i(p2_point),
    .dig3_o(dig3), .dig2_o(dig2), .dig1_o(dig1), .dig0_o(dig0),
    .serve_o(serve), .game_active_o(game_active), .game_over_o(game_over),
    .winner_o(winner)
  );

  // Match rules: does score s beat opponent score o?
  function automatic bit m_won(input int s, input int o);
`ifdef SCORE_DEUCE_EN
    return ((s >= WIN) && (s - o >= 2)) || (s == 99);
`else
    return s == WIN;
`endif
  endfunction

  task automatic model_step(input bit r, input bit st, input bit tk, input bit a, input bit b);
    if (r) begin
      m_phase = PH_IDLE; m_p1 = 0; m_p2 = 0; m_ticks = 0; m_serve = 1'b0; m_winner = 2'b00;
      return;
    end
    m_serve = 1'b0;
    case (m_phase)
      PH_IDLE, PH_OVER: if (st) begin
        m_p1 = 0; m_p2 = 0; m_winner = 2'b00; m_ticks = 0; m_phase = PH_SERVE;
      end
      PH_SERVE: if (tk) begin
        m_ticks++;
        if (m_ticks == DELAY) begin
          m_serve = 1'b1; m_ticks = 0; m_phase = PH_PLAY;
        end
      end
      PH_PLAY: if (a != b) begin
        if (a) begin
          if (m_p1 < 99) m_p1++;
          if (m_won(m_p1, m_p2)) begin m_phase = PH_OVER; m_winner = 2'b01; end
          else begin m_phase = PH_SERVE; m_ticks = 0; end
        end else begin
          if (m_p2 < 99) m_p2++;
          if (m_won(m_p2, m_p1)) begin m_phase = PH_OVER; m_winner = 2'b10; end
          else begin m_phase = PH_SERVE; m_ticks = 0; end
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [20:0] exp_vec();
    return {4'(m_p1 / 10), 4'(m_p1 % 10), 4'(m_p2 / 10), 4'(m_p2 % 10), m_serve,
            (m_phase == PH_SERVE) || (m_phase == PH_PLAY), m_phase == PH_OVER, m_winner};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {dig3, dig2, dig1, dig0, serve, game_active, game_over, winner};
  endfunction

  // Apply one cycle of inputs, advance the model, sample 1 unit after the edge.
  task automatic drive(input bit r, input bit st, input bit tk, input bit a, input bit b);
    @(negedge clk);
    reset = r; start = st; refr_tick = tk; p1_point = a; p2_point = b;
    @(posedge clk);
    model_step(r, st, tk, a, b);
    #1;
  endtask

  // Run the serve delay with random tick spacing and stray ignored pulses.
  task automatic run_serve(output int serves, output bit timeout);
    serves = 0;
    timeout = 1'b0;
    for (int i = 0; (i < 4 * DELAY + 8) && (m_phase == PH_SERVE); i++) begin
      drive(1'b0, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      if (serve === 1'b1) serves++;
    end
    if (m_phase == PH_SERVE) timeout = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (serve === 1'b1) serves++;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (dut_vec() !== 21'd0) begin
      n_err++; $display("FAIL reset_state: got %h expected %h", dut_vec(), 21'd0);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'(i % 2), 1'b0);
      n_vec++;
      if (dut_vec() !== 21'd0) begin
        n_err++; $display("FAIL idle_hold cyc %0d: got %h expected %h", i, dut_vec(), 21'd0);
      end
    end
  endtask

  task automatic test_first_serve();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL start_to_serve: got %h expected %h", dut_vec(), exp_vec());
    end
    for (int i = 1; i <= DELAY; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (serve !== (i == DELAY)) begin
        n_err++; $display("FAIL serve_timing tick %0d: serve=%b expected %b", i, serve, i == DELAY);
      end
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if ((dut_vec() !== exp_vec()) || ({dig3, dig2, dig1, dig0} !== 16'h0000) || (game_active !== 1'b1)) begin
      n_err++; $display("FAIL first_play: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_p1_ten_points();
    int  s;
    bit  t;
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL p1_point %0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
      run_serve(s, t);
      n_vec++;
      if ((s != 1) || t || (game_active !== 1'b1)) begin
        n_err++; $display("FAIL serve_after_point %0d: serves=%0d timeout=%b active=%b expected 1 0 1",
                          k, s, t, game_active);
      end
    end
    n_vec++;
    if ((dig3 !== 4'd1) || (dig2 !== 4'd0)) begin
      n_err++; $display("FAIL p1_ten: got %0d%0d expected 10", dig3, dig2);
    end
  endtask

  task automatic test_simultaneous();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if ((dut_vec() !== exp_vec()) || ({dig3, dig2, dig1, dig0} !== 16'h1000)) begin
      n_err++; $display("FAIL both_points: got %h expected %h", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      n_vec++;
      if ((dut_vec() !== exp_vec()) || (serve !== 1'b0) || (game_active !== 1'b1)) begin
        n_err++; $display("FAIL both_points_hold cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_p1_win();
    int s;
    bit t;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL p2_point %0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
      run_serve(s, t);
      n_vec++;
      if ((s != 1) || t) begin
        n_err++; $display("FAIL p2_serve %0d: serves=%0d timeout=%b expected 1 0", k, s, t);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (({dig3, dig2, dig1, dig0} !== 16'h1103) || (game_over !== 1'b1) || (winner !== 2'b01) ||
        (serve !== 1'b0) || (game_active !== 1'b0)) begin
      n_err++; $display("FAIL p1_win: got %h expected digits 1103 over=1 winner=01", dut_vec());
    end
    for (int i = 0; i < 2 * DELAY; i++) begin
      drive(1'b0, 1'b0, 1'b1, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      n_vec++;
      if ((dut_vec() !== exp_vec()) || (serve !== 1'b0)) begin
        n_err++; $display("FAIL over_hold cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if ({dig3, dig2, dig1, dig0} !== 16'h1103) begin
      n_err++; $display("FAIL over_point: got %h expected 1103", {dig3, dig2, dig1, dig0});
    end
  endtask

  task automatic test_tie_break();
    int s;
    bit t;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ((dut_vec() !== exp_vec()) || ({dig3, dig2, dig1, dig0} !== 16'h0000) || (winner !== 2'b00) ||
        (game_over !== 1'b0) || (game_active !== 1'b1)) begin
      n_err++; $display("FAIL restart: got %h expected %h", dut_vec(), exp_vec());
    end
    run_serve(s, t);
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'(k % 2 == 0), 1'(k % 2 == 1));
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL tie_point %0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
      run_serve(s, t);
      n_vec++;
      if ((s != 1) || t) begin
        n_err++; $display("FAIL tie_serve %0d: serves=%0d timeout=%b expected 1 0", k, s, t);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++;
`ifdef SCORE_DEUCE_EN
    if (({dig3, dig2, dig1, dig0} !== 16'h1110) || (game_over !== 1'b0) || (game_active !== 1'b1)) begin
      n_err++; $display("FAIL deuce_11_10: got %h expected digits 1110 over=0 active=1", dut_vec());
    end
    run_serve(s, t);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (({dig3, dig2, dig1, dig0} !== 16'h1210) || (game_over !== 1'b1) || (winner !== 2'b01)) begin
      n_err++; $display("FAIL deuce_12_10: got %h expected digits 1210 over=1 winner=01", dut_vec());
    end
`else
    if (({dig3, dig2, dig1, dig0} !== 16'h1110) || (game_over !== 1'b1) || (winner !== 2'b01)) begin
      n_err++; $display("FAIL win_11_10: got %h expected digits 1110 over=1 winner=01", dut_vec());
    end
`endif
  endtask

  task automatic test_reset_in_over();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (dut_vec() !== 21'd0) begin
      n_err++; $display("FAIL reset_over: got %h expected %h", dut_vec(), 21'd0);
    end
    for (int i = 0; i < 2 * DELAY; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (dut_vec() !== 21'd0) begin
        n_err++; $display("FAIL idle_after_reset cyc %0d: got %h expected %h", i, dut_vec(), 21'd0);
      end
    end
  endtask

  task automatic test_reset_mid_serve();
    int s;
    bit t;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DELAY / 2; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (dut_vec() !== 21'd0) begin
      n_err++; $display("FAIL reset_serve: got %h expected %h", dut_vec(), 21'd0);
    end
    for (int i = 0; i < 2 * DELAY; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if ((dut_vec() !== 21'd0) || (serve !== 1'b0)) begin
        n_err++; $display("FAIL no_resume cyc %0d: got %h expected %h", i, dut_vec(), 21'd0);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_serve(s, t);
    n_vec++;
    if ((s != 1) || t || (dut_vec() !== exp_vec())) begin
      n_err++; $display("FAIL resume_serve: serves=%0d timeout=%b got %h expected 1 0 %h",
                        s, t, dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 15000; i++) begin
      drive($urandom_range(0, 3999) == 0, $urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; refr_tick = 1'b0; p1_point = 1'b0; p2_point = 1'b0;
    test_reset();
    test_first_serve();
    test_p1_ten_points();
    test_simultaneous();
    test_p1_win();
    test_tie_break();
    test_reset_in_over();
    test_reset_mid_serve();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d errors=%0d", n_vec, n_err);
    $fatal(1);
  end

endmodule

// File: doc/pong_score_ctrl.md
Name: pong_score_ctrl

Overview:
- Game-flow and scoreboard controller that sits directly upstream of the on-screen text renderer.
- Counts points for two players as two-digit BCD and drives the four score digit inputs of the text stage: dig3:dig2 for P1, dig1:dig0 for P2.
- Sequences the match: idle/rule screen, serve delay, play, game over.
- Issues a serve pulse to the ball logic and status flags to the top-level RGB mux.

Parameters:
- WIN_SCORE, 11, points needed to win; legal range 1..99.
- SERVE_DELAY, 120, number of refr_tick frames to wait before each serve; legal range 1..1023.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high reset
- refr_tick  in  1  one-cycle pulse per video frame (60 Hz)
- start  in  1  debounced one-cycle start pulse
- p1_point  in  1  one-cycle pulse: ball passed P2's paddle, P1 scores
- p2_point  in  1  one-cycle pulse: ball passed P1's paddle, P2 scores
- dig3  out  4  P1 tens, BCD
- dig2  out  4  P1 ones, BCD
- dig1  out  4  P2 tens, BCD
- dig0  out  4  P2 ones, BCD
- serve  out  1  one-cycle pulse that launches the ball
- game_active  out  1  high in SERVE and PLAY
- game_over  out  1  high in OVER
- winner  out  2  00 none, 01 P1, 10 P2

Behaviour:
- All outputs are registered.
- Reset state:
  - State IDLE.
  - All digits 0, serve=0, game_active=0, game_over=0, winner=00, delay counter 0.
  - Reset dominates every other input in the same cycle.
- States: IDLE, SERVE, PLAY, OVER.
- IDLE:
  - Digits hold their current value; this state shows the rule screen.
  - On start: clear all digits and winner, clear the delay counter, go to SERVE.
- SERVE:
  - Delay counter increments on each refr_tick.
  - On the refr_tick where the counter reaches SERVE_DELAY-1: pulse serve=1 for exactly one clk cycle, reset the counter, go to PLAY.
  - Point pulses and start are ignored.
- PLAY:
  - p1_point alone: P1 score +1.
  - p2_point alone: P2 score +1.
  - Both pulses in the same cycle: both ignored, stay in PLAY.
  - The new digit value is visible on the cycle after the pulse.
  - Next state:
    - If the new score equals WIN_SCORE: go to OVER, game_over=1, winner set to the scorer.
    - Otherwise: go to SERVE, counter 0.
  - start is ignored.
- OVER:
  - Scores, winner and game_over held.
  - On start: clear digits and winner, game_over=0, go to SERVE.
- BCD increment:
  - Ones 9 → 0 with a carry into tens.
  - 99 saturates at 99 (unreachable with legal WIN_SCORE).
- A binary shadow count (7 bits) is kept per player and compared against WIN_SCORE. BCD and binary must always agree.
- Point pulses outside PLAY never change scores.
- serve is never asserted outside the SERVE→PLAY transition.

Optional Feature:
- Macro: SCORE_DEUCE_EN.
- Defined: win by two.
  - A player wins only when their score ≥ WIN_SCORE and it leads the opponent by ≥ 2.
  - Play continues past WIN_SCORE (e.g. 11:10 → SERVE).
  - The score cap stays at 99: if either player reaches 99 without a 2-point lead, the player who scored last wins.
- Undefined: first to WIN_SCORE wins; no lead comparison logic is synthesized.

Test Plan:
1. Reset; start; count 120 refr_ticks → serve high for exactly one cycle after the 120th tick, state PLAY, digits 0,0,0,0.
2. In PLAY, 10 separate p1_point pulses (each followed by a full serve delay) → dig3=1, dig2=0; serve pulses after each point; game_active=1.
3. P1 reaches 11 with P2 at 3 → dig3:dig2=1:1, dig1:dig0=0:3, game_over=1, winner=01, serve stays 0; a later p2_point leaves digits unchanged.
4. p1_point and p2_point in the same PLAY cycle → scores unchanged, state stays PLAY, no serve.
5. With SCORE_DEUCE_EN and the score at 10:10, P1 scores, then P1 scores again → 11:10 gives no game over; 12:10 gives game_over=1, winner=01.
6. reset asserted in the middle of SERVE and in OVER → next cycle all digits 0, winner=00, flags 0, state IDLE; start is required to resume.
